// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: resolves ID-stage branches, redirects the PC and bubbles IF/ID for FLUSH_DEPTH cycles
module branch_flush_ctrl #(
    parameter int WIDTH       = 16,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bl,
    input  logic             br,
    input  logic             beq,
    input  logic             bne,
    input  logic [WIDTH-1:0] rd1_sel,
    input  logic [WIDTH-1:0] rd2_sel,
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic [WIDTH-1:0] target_addr,
    output logic             pc_load,
    output logic [WIDTH-1:0] redirect_addr,
    output logic [3:0]       branch_select,
    output logic             flush_nop,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data,
    output logic             busy,
    output logic [CNT_W-1:0] taken_count
);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state, state_nx;
    logic [2:0] cnt;
    logic armed, eq, taken, accept;
    logic [3:0] sel;
    assign eq     = rd1_sel == rd2_sel;
    assign taken  = bl | br | (beq & eq) | (bne & ~eq);
    assign accept = state == IDLE && armed && !stall && taken;
    assign sel    = bl ? 4'b1000 : br ? 4'b0100 : (beq & eq) ? 4'b0010 : 4'b0001;
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // next state: leave FLUSH on the last unstalled bubble
    always_comb
        state_nx = state == IDLE ? (accept ? FLUSH : IDLE)
                                 : ((cnt == 3'd1 && !stall) ? IDLE : FLUSH);
    // state-decoded outputs
    always_comb begin
        flush_nop = state == FLUSH;
        busy      = state == FLUSH;
    end
    // redirect/link registers, bubble counter, statistics; armed blocks the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed         <= 1'b0;
            cnt           <= '0;
            pc_load       <= 1'b0;
            branch_select <= '0;
            link_we       <= 1'b0;
            redirect_addr <= '0;
            link_data     <= '0;
            taken_count   <= '0;
        end else begin
            armed         <= 1'b1;
            pc_load       <= accept;
            link_we       <= accept & bl;
            branch_select <= accept ? sel : 4'b0000;
            cnt           <= accept ? 3'(FLUSH_DEPTH) : (state == FLUSH && !stall) ? cnt - 3'd1 : cnt;
            if (accept) begin
                redirect_addr <= (sel == 4'b0100) ? rd1_sel : target_addr;
                link_data     <= pc_plus1;
                taken_count   <= &taken_count ? taken_count : taken_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_flush_ctrl.sv
// tb_branch_flush_ctrl: directed vectors across three parameterisations sharing one stimulus
module tb_branch_flush_ctrl;
    logic clk = 1'b0, rst_n, stall, bl, br, beq, bne;
    logic [15:0] rd1, rd2, pc_plus1, target;
    logic a_pl, a_fn, a_lw, a_bz, b_pl, b_fn, b_lw, b_bz, c_pl, c_fn, c_lw, c_bz;
    logic [15:0] a_ra, a_ld, b_ra, b_ld, c_ra, c_ld, a_tc, b_tc;
    logic [3:0] a_bs, b_bs, c_bs;
    logic [1:0] c_tc;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    branch_flush_ctrl #(.FLUSH_DEPTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .stall(stall), .bl(bl), .br(br), .beq(beq), .bne(bne),
        .rd1_sel(rd1), .rd2_sel(rd2), .pc_plus1(pc_plus1), .target_addr(target), .pc_load(a_pl), .redirect_addr(a_ra),
        .branch_select(a_bs), .flush_nop(a_fn), .link_we(a_lw), .link_data(a_ld), .busy(a_bz), .taken_count(a_tc));
    branch_flush_ctrl #(.FLUSH_DEPTH(3)) dut_b (.clk(clk), .rst_n(rst_n), .stall(stall), .bl(bl), .br(br), .beq(beq), .bne(bne),
        .rd1_sel(rd1), .rd2_sel(rd2), .pc_plus1(pc_plus1), .target_addr(target), .pc_load(b_pl), .redirect_addr(b_ra),
        .branch_select(b_bs), .flush_nop(b_fn), .link_we(b_lw), .link_data(b_ld), .busy(b_bz), .taken_count(b_tc));
    branch_flush_ctrl #(.FLUSH_DEPTH(1), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .stall(stall), .bl(bl), .br(br), .beq(beq), .bne(bne),
        .rd1_sel(rd1), .rd2_sel(rd2), .pc_plus1(pc_plus1), .target_addr(target), .pc_load(c_pl), .redirect_addr(c_ra),
        .branch_select(c_bs), .flush_nop(c_fn), .link_we(c_lw), .link_data(c_ld), .busy(c_bz), .taken_count(c_tc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; bl = 0; br = 0; beq = 0; bne = 0;
        rd1 = 0; rd2 = 0; pc_plus1 = 0; target = 0;
        #12;
        check("rst_pc_load", a_pl, 0); check("rst_redirect", a_ra, 0); check("rst_sel", a_bs, 0);
        check("rst_flush", a_fn, 0); check("rst_link_we", a_lw, 0); check("rst_link_data", a_ld, 0);
        check("rst_busy", a_bz, 0); check("rst_count", a_tc, 0);
        beq = 1; rd1 = 16'h00A5; rd2 = 16'h00A5; target = 16'h0040;
        @(negedge clk) rst_n = 1;
        step; check("first_edge_ignored", a_pl, 0); check("first_edge_flush", a_fn, 0);
        step;
        check("beq_pc_load", a_pl, 1); check("beq_redirect", a_ra, 16'h0040); check("beq_sel", a_bs, 4'b0010);
        check("beq_flush", a_fn, 1); check("beq_count", a_tc, 1); check("beq_link_we", a_lw, 0); check("beq_b_flush", b_fn, 1);
        beq = 0;
        step;
        check("beq_flush_end", a_fn, 0); check("beq_pl_one_cycle", a_pl, 0); check("redirect_held", a_ra, 16'h0040);
        check("b_flush_cont", b_fn, 1); check("b_pl_one_cycle", b_pl, 0);
        step; step; check("b_idle_after_3", b_bz, 0);
        bne = 1; rd1 = 16'h0001; rd2 = 16'h0001;
        step; check("bne_eq_no_load", a_pl, 0); check("bne_eq_no_flush", a_fn, 0); check("bne_eq_count", a_tc, 1);
        rd2 = 16'h0002; target = 16'h0077;
        step; check("bne_sel", a_bs, 4'b0001); check("bne_redirect", a_ra, 16'h0077);
        bne = 0;
        repeat (3) step; check("b_idle_after_bne", b_bz, 0);
        bl = 1; br = 1; rd1 = 16'h1234; pc_plus1 = 16'h0011; target = 16'h0200;
        step;
        check("blbr_sel", a_bs, 4'b1000); check("blbr_redirect", a_ra, 16'h0200); check("blbr_link_we", a_lw, 1);
        check("blbr_link_data", a_ld, 16'h0011); check("c_count_3", c_tc, 2'b11);
        bl = 0;
        step; check("link_we_drop", a_lw, 0); check("link_data_held", a_ld, 16'h0011);
        step;
        check("br_sel", a_bs, 4'b0100); check("br_redirect", a_ra, 16'h1234);
        check("b_ignores_in_flush", b_pl, 0); check("b_count_3", b_tc, 3); check("c_sat_4", c_tc, 2'b11);
        br = 0;
        step; check("b_idle_before_stall", b_bz, 0);
        beq = 1; rd2 = 16'h1234;
        step; check("stall_tst_pl", b_pl, 1); check("stall_tst_nop1", b_fn, 1); check("b_count_4", b_tc, 4); check("c_sat_5", c_tc, 2'b11);
        beq = 0; bl = 1;
        step; check("stall_tst_nop2", b_fn, 1); check("stall_tst_pl_drop", b_pl, 0);
        bl = 0; stall = 1;
        step; check("stall_tst_nop3", b_fn, 1);
        step; check("stall_tst_nop4", b_fn, 1); check("stall_tst_pl_low", b_pl, 0);
        stall = 0;
        step; check("stall_tst_nop5", b_fn, 1);
        step; check("stall_tst_end", b_fn, 0); check("stall_tst_idle", b_bz, 0); check("b_count_bl_ignored", b_tc, 4);
        stall = 1; beq = 1;
        step; check("idle_stall_no_load", b_pl, 0); check("idle_stall_idle", b_bz, 0); check("idle_stall_count", b_tc, 4);
        stall = 0;
        step; check("unstalled_load", b_pl, 1); check("b_count_5", b_tc, 5);
        beq = 0;
        step; check("second_flush_cycle", b_fn, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_pl", b_pl, 0); check("mid_rst_flush", b_fn, 0); check("mid_rst_busy", b_bz, 0);
        check("mid_rst_count", b_tc, 0); check("mid_rst_redirect", b_ra, 0); check("mid_rst_link_data", b_ld, 0);
        check("mid_rst_sel", b_bs, 0); check("mid_rst_link_we", b_lw, 0);
        beq = 1;
        @(negedge clk) rst_n = 1;
        step; check("post_rst_first_edge", b_pl, 0);
        step;
        check("post_rst_pl", b_pl, 1); check("post_rst_redirect", b_ra, 16'h0200);
        check("post_rst_count", b_tc, 1); check("post_rst_flush", b_fn, 1);
        beq = 0;
        repeat (3) step; check("post_rst_idle", b_bz, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
